// File: rtl/picomips_stim_host.sv
// ============================================================================
// Module  : picomips_stim_host
// Brief   : Automated stimulus/response host for the picoMIPS switch/LED port.
// Revision: 1.0
// ============================================================================
`default_nettype none

module picomips_stim_host #(
    parameter int SETUP = 2,
    parameter int HOLD  = 8,
    parameter int RWAIT = 16,
    parameter int CW    = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       vec_valid,
    output logic       vec_ready,
    input  logic [7:0] vec_x,
    input  logic [7:0] vec_y,
    input  logic [7:0] exp_x,
    input  logic [7:0] exp_y,
    input  logic       vec_last,
    output logic [7:0] sw,
    output logic       bstus,
    input  logic [7:0] led,
    output logic       res_valid,
    output logic [7:0] res_x,
    output logic [7:0] res_y,
    output logic       res_ok,
    output logic       busy,
    output logic       done,
    output logic [7:0] pass_cnt,
    output logic [7:0] fail_cnt
);

    localparam logic [3:0] S_IDLE  = 4'd0;
    localparam logic [3:0] S_FETCH = 4'd1;
    localparam logic [3:0] S_SETX  = 4'd2;
    localparam logic [3:0] S_STRX  = 4'd3;
    localparam logic [3:0] S_SETY  = 4'd4;
    localparam logic [3:0] S_STRY  = 4'd5;
    localparam logic [3:0] S_WRX   = 4'd6;
    localparam logic [3:0] S_WRY   = 4'd7;
    localparam logic [3:0] S_CHECK = 4'd8;
    localparam logic [3:0] S_DONE  = 4'd9;

    localparam logic [CW-1:0] c_setup_ld = CW'(SETUP - 1);
    localparam logic [CW-1:0] c_hold_ld  = CW'(HOLD - 1);
    localparam logic [CW-1:0] c_rwait_ld = CW'(RWAIT - 1);

    logic [3:0]    r_state;
    logic [3:0]    w_next;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_load;
    logic          w_tdone;

    logic [7:0] r_sw;
    logic       r_bstus;
    logic [7:0] r_vy;
    logic [7:0] r_ex;
    logic [7:0] r_ey;
    logic       r_last;
    logic [7:0] r_res_x;
    logic [7:0] r_res_y;
    logic       r_res_ok;
    logic       r_res_valid;
    logic [7:0] r_pass;
    logic [7:0] r_fail;

    assign w_tdone = (r_cnt == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start)     w_next = S_FETCH;
            S_FETCH: if (vec_valid) w_next = S_SETX;
            S_SETX:  if (w_tdone)   w_next = S_STRX;
            S_STRX:  if (w_tdone)   w_next = S_SETY;
            S_SETY:  if (w_tdone)   w_next = S_STRY;
            S_STRY:  if (w_tdone)   w_next = S_WRX;
            S_WRX:   if (w_tdone)   w_next = S_WRY;
            S_WRY:   if (w_tdone)   w_next = S_CHECK;
            S_CHECK: w_next = r_last ? S_DONE : S_FETCH;
            S_DONE:  if (start)     w_next = S_FETCH;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        vec_ready = (r_state == S_FETCH);
        busy      = (r_state != S_IDLE) && (r_state != S_DONE);
        done      = (r_state == S_DONE);
    end

    // Wait count loaded for the state being entered, so a state lasts exactly N cycles.
    always_comb begin
        w_load = '0;
        case (w_next)
            S_SETX, S_SETY: w_load = c_setup_ld;
            S_STRX, S_STRY: w_load = c_hold_ld;
            S_WRX, S_WRY:   w_load = c_rwait_ld;
            default:        w_load = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt       <= '0;
            r_sw        <= '0;
            r_bstus     <= 1'b0;
            r_vy        <= '0;
            r_ex        <= '0;
            r_ey        <= '0;
            r_last      <= 1'b0;
            r_res_x     <= '0;
            r_res_y     <= '0;
            r_res_ok    <= 1'b0;
            r_res_valid <= 1'b0;
            r_pass      <= '0;
            r_fail      <= '0;
        end else begin
            r_res_valid <= 1'b0;
            if (w_next != r_state)  r_cnt <= w_load;
            else if (r_cnt != '0)   r_cnt <= r_cnt - 1'b1;

            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_pass <= '0;
                        r_fail <= '0;
                    end
                end
                S_FETCH: begin
                    if (vec_valid) begin
                        r_sw   <= vec_x;
                        r_vy   <= vec_y;
                        r_ex   <= exp_x;
                        r_ey   <= exp_y;
                        r_last <= vec_last;
                    end
                end
                S_SETX: if (w_tdone) r_bstus <= 1'b1;
                S_STRX: if (w_tdone) r_sw    <= r_vy;
                S_SETY: if (w_tdone) r_bstus <= 1'b0;
                S_WRX:  if (w_tdone) r_res_x <= led;
                S_WRY: begin
                    if (w_tdone) begin
                        r_res_y     <= led;
                        r_res_ok    <= (r_res_x == r_ex) && (led == r_ey);
                        r_res_valid <= 1'b1;
                    end
                end
                S_CHECK: begin
                    if (r_res_ok) begin
                        if (r_pass != 8'hFF) r_pass <= r_pass + 1'b1;
                    end else begin
                        if (r_fail != 8'hFF) r_fail <= r_fail + 1'b1;
                    end
                    if (r_last) r_sw <= '0;
                end
                default: ;
            endcase
        end
    end

    assign sw        = r_sw;
    assign bstus     = r_bstus;
    assign res_x     = r_res_x;
    assign res_y     = r_res_y;
    assign res_ok    = r_res_ok;
    assign res_valid = r_res_valid;
    assign pass_cnt  = r_pass;
    assign fail_cnt  = r_fail;

endmodule

`default_nettype wire

// File: tb/tb_picomips_stim_host.sv
// ============================================================================
// Module  : tb_picomips_stim_host
// Brief   : Directed bench for picomips_stim_host with a picoMIPS result stub.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_picomips_stim_host;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic       start = 0, vv = 0, vl = 0;
    logic [7:0] vx = 0, vy = 0, ex = 0, ey = 0, led = 0, rx = 0, ry = 0;
    logic       vec_ready, bstus, res_valid, res_ok, busy, done;
    logic [7:0] sw, res_x, res_y, pass_cnt, fail_cnt;

    logic       start2 = 0, vv2 = 0, vl2 = 0;
    logic [7:0] vx2 = 8'h33, vy2 = 8'h44, ex2 = 8'h55, ey2 = 8'h66, led2 = 0;
    logic [7:0] rx2 = 8'h55, ry2 = 8'h66;
    logic       vec_ready2, bstus2, res_valid2, res_ok2, busy2, done2;
    logic [7:0] sw2, res_x2, res_y2, pass_cnt2, fail_cnt2;

    int checks = 0;
    int failures = 0;

    picomips_stim_host dut (
        .clk(clk), .reset(reset), .start(start), .vec_valid(vv), .vec_ready(vec_ready),
        .vec_x(vx), .vec_y(vy), .exp_x(ex), .exp_y(ey), .vec_last(vl),
        .sw(sw), .bstus(bstus), .led(led), .res_valid(res_valid), .res_x(res_x),
        .res_y(res_y), .res_ok(res_ok), .busy(busy), .done(done),
        .pass_cnt(pass_cnt), .fail_cnt(fail_cnt)
    );

    picomips_stim_host #(.SETUP(1), .HOLD(1), .RWAIT(1), .CW(8)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .vec_valid(vv2), .vec_ready(vec_ready2),
        .vec_x(vx2), .vec_y(vy2), .exp_x(ex2), .exp_y(ey2), .vec_last(vl2),
        .sw(sw2), .bstus(bstus2), .led(led2), .res_valid(res_valid2), .res_x(res_x2),
        .res_y(res_y2), .res_ok(res_ok2), .busy(busy2), .done(done2),
        .pass_cnt(pass_cnt2), .fail_cnt(fail_cnt2)
    );

    // picoMIPS stub: shows x2 after the strobe falls, switches to y2 K cycles later.
    int   ka = 255, kb = 255;
    logic pba = 1'b0, pbb = 1'b0;
    always @(negedge clk) begin
        if (pba && !bstus) ka = 0; else if (ka < 255) ka = ka + 1;
        pba = bstus;
        led = (ka < 30) ? rx : ry;
        if (pbb && !bstus2) kb = 0; else if (kb < 255) kb = kb + 1;
        pbb = bstus2;
        led2 = (kb < 2) ? rx2 : ry2;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_rv(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (res_valid !== 1'b1 && n < 400);
    endtask

    initial begin
        int n, w, bad, p;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_sw", sw, 0);           chk("rst_bstus", bstus, 0);
        chk("rst_res_valid", res_valid, 0); chk("rst_res_ok", res_ok, 0);
        chk("rst_res_x", res_x, 0);     chk("rst_pass", pass_cnt, 0);
        chk("rst_fail", fail_cnt, 0);   chk("rst_vec_ready", vec_ready, 0);
        chk("rst_busy", busy, 0);       chk("rst_done", done, 0);
        reset = 0;
        @(negedge clk);

        // T1: one passing vector, exact strobe timing
        vx = 8'h05; vy = 8'h0A; ex = 8'h11; ey = 8'h22; vl = 1; vv = 1;
        rx = 8'h11; ry = 8'h22; start = 1;
        @(negedge clk); start = 0;
        chk("t1_vec_ready", vec_ready, 1); chk("t1_busy", busy, 1);
        @(negedge clk); vx = 8'hEE; vv = 0;
        chk("t1_sw_x", sw, 8'h05);      chk("t1_bstus_c1", bstus, 0);
        @(negedge clk);
        chk("t1_bstus_c2", bstus, 0);
        @(negedge clk);
        chk("t1_bstus_rise", bstus, 1); chk("t1_sw_hold", sw, 8'h05);
        wait_rv(n);
        chk("t1_latency", n, 50);       chk("t1_res_valid", res_valid, 1);
        chk("t1_res_x", res_x, 8'h11);  chk("t1_res_y", res_y, 8'h22);
        chk("t1_res_ok", res_ok, 1);    chk("t1_sw_y", sw, 8'h0A);
        @(negedge clk);
        chk("t1_done", done, 1);        chk("t1_pass", pass_cnt, 1);
        chk("t1_fail", fail_cnt, 0);    chk("t1_busy_done", busy, 0);
        chk("t1_sw_done", sw, 0);       chk("t1_rv_pulse", res_valid, 0);
        chk("t1_res_ok_held", res_ok, 1);

        // T2: same vector, wrong y result
        vx = 8'h05; vv = 1; ry = 8'h23; start = 1;
        @(negedge clk); start = 0;
        @(negedge clk); vv = 0;
        wait_rv(n);
        chk("t2_res_valid", res_valid, 1); chk("t2_res_ok", res_ok, 0);
        chk("t2_res_y", res_y, 8'h23);     chk("t2_res_x", res_x, 8'h11);
        @(negedge clk);
        chk("t2_fail", fail_cnt, 1);  chk("t2_pass", pass_cnt, 0);
        chk("t2_done", done, 1);

        // T3: FETCH stalls while vec_valid is low
        vv = 0; vl = 0; ry = 8'h22; start = 1;
        @(negedge clk); start = 0;
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            if (vec_ready !== 1'b1 || sw !== 8'h00 || bstus !== 1'b0) bad++;
            @(negedge clk);
        end
        chk("t3_stall", bad, 0);
        vv = 1; vl = 1;
        @(negedge clk); vv = 0;
        wait_rv(n);
        chk("t3_res_ok", res_ok, 1);
        @(negedge clk);
        chk("t3_pass", pass_cnt, 1);  chk("t3_done", done, 1);

        // T4: 260 failing vectors saturate fail_cnt
        rx = 8'h00; ry = 8'h00; vl = 0; vv = 1; start = 1;
        @(negedge clk); start = 0;
        for (int i = 0; i < 260; i++) begin
            w = 0;
            while (vec_ready !== 1'b1 && w < 200) begin @(negedge clk); w++; end
            vl = (i == 259);
            @(negedge clk);
        end
        vv = 0;
        w = 0;
        while (done !== 1'b1 && w < 200) begin @(negedge clk); w++; end
        chk("t4_done", done, 1);
        chk("t4_fail_sat", fail_cnt, 255);
        chk("t4_pass", pass_cnt, 0);

        // T5: asynchronous reset while the x strobe is high
        rx = 8'h11; ry = 8'h22; vx = 8'h05; vl = 1; vv = 1; start = 1;
        @(negedge clk); start = 0;
        @(negedge clk); vv = 0;
        w = 0;
        while (bstus !== 1'b1 && w < 20) begin @(negedge clk); w++; end
        chk("t5_in_strx", bstus, 1);
        @(negedge clk);
        reset = 1;
        #1;
        chk("t5_bstus_async", bstus, 0); chk("t5_sw_async", sw, 0);
        chk("t5_busy_async", busy, 0);   chk("t5_fail_async", fail_cnt, 0);
        @(negedge clk); reset = 0;
        chk("t5_vec_ready", vec_ready, 0);
        vv = 1; start = 1;
        @(negedge clk); start = 0;
        @(negedge clk); vv = 0;
        wait_rv(n);
        chk("t5_res_ok", res_ok, 1);
        @(negedge clk);
        chk("t5_pass", pass_cnt, 1);  chk("t5_done", done, 1);

        // T6: minimum timing, back-to-back vectors
        start2 = 1; vv2 = 1; vl2 = 0;
        @(negedge clk); start2 = 0;
        chk("t6_fetch", vec_ready2, 1);
        @(negedge clk);
        for (int j = 0; j < 16; j++) begin
            p = j % 8;
            chk($sformatf("t6_bstus_%0d", j), bstus2, (p == 1 || p == 2) ? 1 : 0);
            chk($sformatf("t6_ready_%0d", j), vec_ready2, (p == 7) ? 1 : 0);
            chk($sformatf("t6_rv_%0d", j), res_valid2, (p == 6) ? 1 : 0);
            chk($sformatf("t6_sw_%0d", j), sw2, (p < 2) ? 8'h33 : 8'h44);
            if (p == 6) chk($sformatf("t6_ok_%0d", j), res_ok2, 1);
            if (j == 14) vl2 = 1;
            @(negedge clk);
        end
        vv2 = 0;
        w = 0;
        while (done2 !== 1'b1 && w < 20) begin @(negedge clk); w++; end
        chk("t6_done", done2, 1);
        chk("t6_pass", pass_cnt2, 3);
        chk("t6_fail", fail_cnt2, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
